// File: rtl/demux1_8_buf_if.sv
// Bundle of the demux1_8_buf data, handshake and status signals.
// master = upstream producer plus the eight consumers; slave = demux1_8_buf.
interface demux1_8_buf_if #(
  parameter int DataPathSize = 2
);
  logic [DataPathSize-1:0] IN_DATA;
  logic [2:0]              SEL;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [DataPathSize-1:0] OUT0;
  logic [DataPathSize-1:0] OUT1;
  logic [DataPathSize-1:0] OUT2;
  logic [DataPathSize-1:0] OUT3;
  logic [DataPathSize-1:0] OUT4;
  logic [DataPathSize-1:0] OUT5;
  logic [DataPathSize-1:0] OUT6;
  logic [DataPathSize-1:0] OUT7;
  logic [7:0]              OUT_VALID;
  logic [7:0]              OUT_ACK;
  logic [7:0]              STALL_CNT;

  modport master (
    output IN_DATA, SEL, IN_VALID, OUT_ACK,
    input  IN_READY, OUT0, OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7,
           OUT_VALID, STALL_CNT
  );

  modport slave (
    input  IN_DATA, SEL, IN_VALID, OUT_ACK,
    output IN_READY, OUT0, OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7,
           OUT_VALID, STALL_CNT
  );
endinterface

// File: rtl/demux1_8_buf.sv
// 1-to-8 demultiplexer with a one-word holding register per channel.
// Optional stall counter enabled by defining DEMUX_STALL_CNT_EN.
module demux1_8_buf #(
  parameter int DataPathSize = 2
) (
  input  logic            CLK,
  input  logic            RST,
  demux1_8_buf_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t               state_q [8];
  ch_state_t               state_d [8];
  logic [DataPathSize-1:0] data_q  [8];
  logic [7:0]              valid;
  logic [7:0]              ack;
  logic [7:0]              load;
  logic                    ready;
  logic                    xfer;

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      valid[i[2:0]] = (state_q[i] == FULL);
    end
  end

  assign ack = bus.OUT_ACK;

  // A full channel can still accept when its consumer pops in the same cycle.
  assign ready = !valid[bus.SEL] || ack[bus.SEL];
  assign xfer  = bus.IN_VALID && ready;

  always_comb begin
    load = '0;
    if (xfer) begin
      load[bus.SEL] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY: if (load[i[2:0]]) state_d[i] = FULL;
        FULL:  if (ack[i[2:0]] && !load[i[2:0]]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 8; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        state_q[i] <= state_d[i];
        if (load[i[2:0]]) begin
          data_q[i] <= bus.IN_DATA;
        end
      end
    end
  end

`ifdef DEMUX_STALL_CNT_EN
  logic [7:0] stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
    end else if (bus.IN_VALID && !ready && (stall_q != '1)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign bus.STALL_CNT = stall_q;
`else
  assign bus.STALL_CNT = '0;
`endif

  assign bus.IN_READY  = ready;
  assign bus.OUT_VALID = valid;
  assign bus.OUT0      = data_q[0];
  assign bus.OUT1      = data_q[1];
  assign bus.OUT2      = data_q[2];
  assign bus.OUT3      = data_q[3];
  assign bus.OUT4      = data_q[4];
  assign bus.OUT5      = data_q[5];
  assign bus.OUT6      = data_q[6];
  assign bus.OUT7      = data_q[7];

endmodule

// File: tb/tb_demux1_8_buf.sv
// Self-checking bench for demux1_8_buf: directed scenarios plus random traffic
// compared against a per-channel array model.
module tb_demux1_8_buf;
  localparam int W = 2;

  logic CLK = 1'b0;
  logic RST;

  demux1_8_buf_if #(.DataPathSize(W)) bus ();

  demux1_8_buf #(.DataPathSize(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_data  [8];
  logic         m_valid [8];
  int           m_stall;
  logic [W-1:0] outs    [8];

  always_comb begin
    outs[0] = bus.OUT0; outs[1] = bus.OUT1; outs[2] = bus.OUT2; outs[3] = bus.OUT3;
    outs[4] = bus.OUT4; outs[5] = bus.OUT5; outs[6] = bus.OUT6; outs[7] = bus.OUT7;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_valid_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_valid[k];
    return v;
  endfunction

  // One clock cycle: drive, check ready mid-cycle, advance model, check state.
  task automatic step(input logic r, input logic [W-1:0] d, input logic [2:0] s,
                      input logic v, input logic [7:0] a);
    logic exp_ready;
    logic xfer;
    RST          = r;
    bus.IN_DATA  = d;
    bus.SEL      = s;
    bus.IN_VALID = v;
    bus.OUT_ACK  = a;
    #4;
    exp_ready = !m_valid[s] || a[s];
    check("in_ready", {31'd0, bus.IN_READY}, {31'd0, exp_ready});
    @(posedge CLK);
    #1;
    xfer = v && exp_ready;
    if (r) begin
      for (int k = 0; k < 8; k++) begin
        m_data[k]  = '0;
        m_valid[k] = 1'b0;
      end
      m_stall = 0;
    end else begin
`ifdef DEMUX_STALL_CNT_EN
      if (v && !exp_ready && m_stall < 255) m_stall++;
`endif
      for (int k = 0; k < 8; k++) begin
        if (xfer && int'(s) == k) begin
          m_data[k]  = d;
          m_valid[k] = 1'b1;
        end else if (a[k]) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    check("out_valid", {24'd0, bus.OUT_VALID}, {24'd0, model_valid_vec()});
    check("stall_cnt", {24'd0, bus.STALL_CNT}, m_stall);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("out%0d", k), {{(32-W){1'b0}}, outs[k]}, {{(32-W){1'b0}}, m_data[k]});
    end
  endtask

  task automatic do_reset();
    step(1'b1, '0, 3'd0, 1'b0, 8'h00);
    step(1'b1, '0, 3'd0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [W-1:0] hold3;
    for (int k = 0; k < 8; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_stall      = 0;
    RST          = 1'b1;
    bus.IN_DATA  = '0;
    bus.SEL      = '0;
    bus.IN_VALID = 1'b0;
    bus.OUT_ACK  = '0;
    @(posedge CLK);
    #1;
    do_reset();
    check("reset_valid", {24'd0, bus.OUT_VALID}, 32'h00);

    // Single transfer to channel 5
    step(1'b0, 2'b10, 3'd5, 1'b1, 8'h00);
    check("ch5_valid", {24'd0, bus.OUT_VALID}, 32'h20);
    check("ch5_data", {30'd0, bus.OUT5}, 32'h2);

    // Channel 3 full, four stalled cycles
    do_reset();
    step(1'b0, 2'b01, 3'd3, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b11, 3'd3, 1'b1, 8'h00);
    check("stall_ch3_data", {30'd0, bus.OUT3}, 32'h1);
`ifdef DEMUX_STALL_CNT_EN
    check("stall4", {24'd0, bus.STALL_CNT}, 32'd4);
`else
    check("stall4", {24'd0, bus.STALL_CNT}, 32'd0);
`endif

    // Pop and push in the same cycle
    step(1'b0, 2'b11, 3'd3, 1'b1, 8'h08);
    check("popush_data", {30'd0, bus.OUT3}, 32'h3);
    check("popush_valid", {31'd0, bus.OUT_VALID[3]}, 32'd1);

    // Fill all channels, then ack all together
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, W'(k % 4), 3'(k), 1'b1, 8'h00);
    check("all_full", {24'd0, bus.OUT_VALID}, 32'hFF);
    step(1'b0, '0, 3'd0, 1'b0, 8'hFF);
    check("all_acked", {24'd0, bus.OUT_VALID}, 32'h00);
    check("ch7_data_kept", {30'd0, bus.OUT7}, 32'h3);

    // Reset wins over a coincident transfer
    do_reset();
    step(1'b0, 2'b11, 3'd0, 1'b1, 8'h00);
    step(1'b1, 2'b10, 3'd1, 1'b1, 8'h00);
    check("rst_prio_valid", {24'd0, bus.OUT_VALID}, 32'h00);
    check("rst_prio_out0", {30'd0, bus.OUT0}, 32'h0);

    // Long stall for saturation
    do_reset();
    step(1'b0, 2'b01, 3'd3, 1'b1, 8'h00);
    for (int i = 0; i < 300; i++) step(1'b0, 2'b10, 3'd3, 1'b1, 8'h00);
`ifdef DEMUX_STALL_CNT_EN
    check("stall_sat", {24'd0, bus.STALL_CNT}, 32'hFF);
`else
    check("stall_sat", {24'd0, bus.STALL_CNT}, 32'h00);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      hold3 = W'($urandom);
      step(($urandom_range(0, 99) == 0), hold3, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), 8'($urandom) & 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1_8_buf.md
DEMUX1_8_BUF -- requirements
Module: demux1_8_buf

Interface
REQ-001 Parameter DataPathSize, default 2, width in bits of every data port.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 IN_DATA  input  DataPathSize  word offered for distribution.
REQ-005 SEL  input  3  destination channel; 3'b000..3'b111 select channel 0..7.
REQ-006 IN_VALID  input  1  IN_DATA/SEL valid this cycle.
REQ-007 IN_READY  output  1  block accepts the offered word this cycle; combinational.
REQ-008 OUT0..OUT7  output  DataPathSize each  per-channel holding registers.
REQ-009 OUT_VALID  output  8  bit k set = OUTk holds an unconsumed word.
REQ-010 OUT_ACK  input  8  bit k pulsed by consumer k to pop OUTk; ignored when OUT_VALID[k]=0.
REQ-011 STALL_CNT  output  8  stall-cycle counter (see Configuration).

Function
REQ-012 Transfer occurs in a cycle when IN_VALID=1 and IN_READY=1.
REQ-013 IN_READY SHALL equal (OUT_VALID[SEL]=0) OR (OUT_ACK[SEL]=1); it SHALL NOT depend on IN_VALID.
REQ-014 On transfer, OUT[SEL] SHALL load IN_DATA and OUT_VALID[SEL] SHALL be 1 at the next edge; latency one cycle.
REQ-015 OUTk for k != SEL SHALL hold their value on a transfer; no other channel is written.
REQ-016 OUT_ACK[k]=1 with OUT_VALID[k]=1 and no transfer to k SHALL clear OUT_VALID[k] at the next edge; OUTk data holds.
REQ-017 Simultaneous OUT_ACK[k] and transfer to channel k: new word SHALL be loaded and OUT_VALID[k] SHALL remain 1 (pop and push in the same cycle).
REQ-018 Acks on multiple channels in one cycle SHALL all be honoured independently.
REQ-019 Channel full (OUT_VALID[SEL]=1, OUT_ACK[SEL]=0): IN_READY=0, no state change on channel SEL; upstream holds IN_DATA/SEL.
REQ-020 Each channel is a 2-state machine EMPTY/FULL: EMPTY->FULL on transfer; FULL->EMPTY on ack without transfer; FULL->FULL on ack with transfer or on no ack.
REQ-021 SEL changing while IN_VALID=1 and IN_READY=0 SHALL be legal; IN_READY re-evaluates against the new SEL in the same cycle.
REQ-022 X or unknown SEL with IN_VALID=0 SHALL NOT alter any state.

Reset
REQ-023 RST=1 at a rising edge SHALL set OUT0..OUT7 to 0, OUT_VALID to 8'h00, STALL_CNT to 8'h00.
REQ-024 RST SHALL take priority over transfers and acks in the same cycle; words in flight are discarded.
REQ-025 While RST=1, IN_READY SHALL follow REQ-013 from the reset-state OUT_VALID, but no transfer takes effect.

Configuration
REQ-026 Macro DEMUX_STALL_CNT_EN: when defined, STALL_CNT SHALL increment by 1 on each cycle with IN_VALID=1 and IN_READY=0, saturating at 8'hFF, cleared only by RST.
REQ-027 When DEMUX_STALL_CNT_EN is not defined, STALL_CNT SHALL be constant 8'h00 and no counter logic SHALL be present; all other behaviour is identical.

Verification
REQ-028 After RST, IN_DATA=2'b10, SEL=3'b101, IN_VALID=1 one cycle -> next cycle OUT5=2'b10, OUT_VALID=8'h20, all other OUTk=0.
REQ-029 Channel 3 full, IN_VALID=1, SEL=3, OUT_ACK=0 for 4 cycles -> IN_READY=0 throughout, OUT3 unchanged, STALL_CNT=4 with macro, 0 without.
REQ-030 Channel 3 full with 2'b01, OUT_ACK[3]=1 and IN_DATA=2'b11, SEL=3, IN_VALID=1 same cycle -> IN_READY=1, next cycle OUT3=2'b11, OUT_VALID[3]=1.
REQ-031 Fill all 8 channels with data k (mod 4), then OUT_ACK=8'hFF one cycle -> OUT_VALID=8'h00, OUT0..OUT7 data unchanged.
REQ-032 Channel 0 full, RST=1 coincident with transfer to channel 1 -> next cycle OUT_VALID=8'h00, OUT0=OUT1=0.
REQ-033 With macro, hold a stall 300 cycles -> STALL_CNT saturates at 8'hFF and stays.
